// File: rtl/sparse_mul_arbiter.sv
// Round-robin arbiter that time-shares one sparse multiplier between NREQ requesters,
// latching the winner's operands and returning the product (or a watchdog abort) to it.
module sparse_mul_arbiter #(
    parameter int NREQ    = 3,
    parameter int R       = 127,
    parameter int W       = 5,
    parameter int POS_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int IDW     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*R-1:0]       req_b,
    input  logic [NREQ*W*POS_W-1:0] req_pos,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [R-1:0]            rsp_c,
    output logic                    rsp_err,
    output logic [IDW-1:0]          grant_id,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    mul_start,
    output logic [R-1:0]            mul_b,
    output logic [W*POS_W-1:0]      mul_pos,
    input  logic [R-1:0]            mul_c,
    input  logic                    mul_done
);

    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] last;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;
    logic           found;
    logic [WDW-1:0] wdog;

    // Scan requesters starting just after the previous owner so nobody starves.
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rsp_valid   <= '0;
            rsp_c       <= '0;
            rsp_err     <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            mul_start   <= 1'b0;
            mul_b       <= '0;
            mul_pos     <= '0;
            last        <= IDW'(NREQ - 1);
            wdog        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id  <= winner;
                        last      <= winner;
                        mul_b     <= req_b[winner*R +: R];
                        mul_pos   <= req_pos[winner*W*POS_W +: W*POS_W];
                        mul_start <= 1'b1;
                        wdog      <= '0;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    mul_start <= 1'b0;
                    // A done coincident with our own start pulse cannot belong to this op.
                    if (mul_done && !mul_start) begin
                        rsp_c     <= mul_c;
                        rsp_valid <= NREQ'(1) << grant_id;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else if (wdog == WDW'(TIMEOUT - 1)) begin
                        rsp_c       <= '0;
                        rsp_valid   <= NREQ'(1) << grant_id;
                        rsp_err     <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_mul_arbiter.sv
// Randomised bench for sparse_mul_arbiter with a transaction-level arbitration model
// and a stub multiplier whose done latency can be changed or suppressed.
module tb_sparse_mul_arbiter;

    localparam int NREQ    = 3;
    localparam int R       = 127;
    localparam int W       = 5;
    localparam int POS_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*R-1:0]       req_b;
    logic [NREQ*W*POS_W-1:0] req_pos;
    logic [NREQ-1:0]         rsp_valid;
    logic [R-1:0]            rsp_c;
    logic                    rsp_err;
    logic [IDW-1:0]          grant_id;
    logic                    busy;
    logic                    timeout_err;
    logic                    mul_start;
    logic [R-1:0]            mul_b;
    logic [W*POS_W-1:0]      mul_pos;
    logic [R-1:0]            mul_c;
    logic                    mul_done;

    int checks = 0;
    int errors = 0;

    int              mul_delay = 4;
    int              mul_cnt   = 0;
    logic            inject    = 1'b0;
    logic [R-1:0]    mul_prod  = '0;
    logic [NREQ-1:0] pending   = '0;
    int              last_ref  = NREQ - 1;

    sparse_mul_arbiter #(
        .NREQ(NREQ), .R(R), .W(W), .POS_W(POS_W), .TIMEOUT(TIMEOUT), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_b(req_b), .req_pos(req_pos),
        .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_err(rsp_err), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err), .mul_start(mul_start), .mul_b(mul_b),
        .mul_pos(mul_pos), .mul_c(mul_c), .mul_done(mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product of b(x) with a sum of monomials x^p modulo x^R - 1.
    function automatic logic [R-1:0] sparse_mul(input logic [R-1:0] b, input logic [W*POS_W-1:0] pos);
        logic [R-1:0] c;
        int p;
        c = '0;
        for (int j = 0; j < W; j++) begin
            p = int'(pos[j*POS_W +: POS_W]) % R;
            c = c ^ ((p == 0) ? b : ((b << p) | (b >> (R - p))));
        end
        return c;
    endfunction

    // Winner is the requester at the smallest forward distance from the previous owner.
    function automatic int pick_winner(input logic [NREQ-1:0] r, input int prev);
        int best, bestd, d;
        best  = -1;
        bestd = NREQ + 1;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - prev - 1 + 2 * NREQ) % NREQ;
            if (r[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    // Stub multiplier: done a fixed number of cycles after start, 0 means never.
    initial begin
        mul_done = 1'b0;
        mul_c    = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_done = 1'b0;
            if (mul_cnt > 0) begin
                mul_cnt--;
                if (mul_cnt == 0) begin
                    mul_done = 1'b1;
                    mul_c    = mul_prod;
                end
            end
            if (inject) begin
                mul_done = 1'b1;
                inject   = 1'b0;
            end
            if (mul_start) begin
                mul_cnt  = mul_delay;
                mul_prod = sparse_mul(mul_b, mul_pos);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [R-1:0] actual, input logic [R-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r);
        logic [127:0] t;
        req = r;
        for (int i = 0; i < NREQ; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            req_b[i*R +: R] = t[R-1:0];
            for (int j = 0; j < W; j++)
                req_pos[(i*W + j)*POS_W +: POS_W] = POS_W'($urandom_range(0, R - 1));
        end
    endtask

    // Runs one operation from an IDLE negedge through to the IDLE after its response.
    task automatic run_op(input logic fixed1, input logic inj_start, input int exp_lat, input logic exp_err);
        int w, lat;
        logic seen;
        logic [R-1:0] eb, expc;
        logic [W*POS_W-1:0] ep;
        applyStimulus(pending);
        if (fixed1) begin
            req_b[R-1:0] = R'(1);
            for (int j = 0; j < W; j++) req_pos[j*POS_W +: POS_W] = POS_W'(j);
        end
        if (inj_start) inject = 1'b1;
        w    = pick_winner(pending, last_ref);
        eb   = req_b[w*R +: R];
        ep   = req_pos[w*W*POS_W +: W*POS_W];
        expc = exp_err ? '0 : sparse_mul(eb, ep);
        @(negedge clk);
        checkOutput("mul_start", R'(mul_start), R'(1));
        checkOutput("grant_id", R'(grant_id), R'(w));
        checkOutput("busy_wait", R'(busy), R'(1));
        checkOutput("mul_b", mul_b, eb);
        checkOutput("mul_pos", R'(mul_pos), R'(ep));
        applyStimulus(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid != '0) seen = 1'b1;
            else if (lat == 1) checkOutput("mul_start_pulse", R'(mul_start), R'(0));
        end
        checkOutput("rsp_seen", R'(seen), R'(1));
        checkOutput("latency", R'(lat), R'(exp_lat));
        checkOutput("rsp_valid", R'(rsp_valid), R'(1 << w));
        checkOutput("rsp_c", rsp_c, expc);
        checkOutput("rsp_err", R'(rsp_err), R'(exp_err));
        checkOutput("mul_b_hold", mul_b, eb);
        last_ref   = w;
        pending[w] = 1'b0;
        req        = '0;
        @(negedge clk);
        checkOutput("rsp_clear", R'(rsp_valid), R'(0));
        checkOutput("busy_idle", R'(busy), R'(0));
        checkOutput("rsp_c_hold", rsp_c, expc);
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput({tag, "_rsp"}, R'(rsp_valid), R'(0));
            checkOutput({tag, "_busy"}, R'(busy), R'(0));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        last_ref = NREQ - 1;
        pending  = '0;
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_b   = '0;
        req_pos = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rsp_valid", R'(rsp_valid), R'(0));
        checkOutput("rst_rsp_c", rsp_c, '0);
        checkOutput("rst_busy", R'(busy), R'(0));
        checkOutput("rst_grant", R'(grant_id), R'(0));
        checkOutput("rst_mul_start", R'(mul_start), R'(0));
        checkOutput("rst_timeout_err", R'(timeout_err), R'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single fixed operation.
        pending = 3'b001;
        run_op(1'b1, 1'b0, 5, 1'b0);
        checkOutput("t1_product", rsp_c, R'(127'h1F));

        // Simultaneous requests from reset, then a partial set.
        do_reset();
        pending = 3'b111;
        repeat (3) run_op(1'b0, 1'b0, 5, 1'b0);
        checkOutput("t2_last", R'(grant_id), R'(2));
        pending = 3'b101;
        repeat (2) run_op(1'b0, 1'b0, 5, 1'b0);

        // Fairness: both keep asking.
        for (int i = 0; i < 10; i++) begin
            pending = 3'b011;
            run_op(1'b0, 1'b0, 5, 1'b0);
        end

        // Spurious done while idle and in the start cycle.
        inject = 1'b1;
        quiet_cycles("spur_idle", 3);
        pending = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        run_op(1'b0, 1'b1, 5, 1'b0);

        // Random traffic with requests accumulating.
        for (int i = 0; i < 20; i++) begin
            pending = pending | NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if (pending == '0) pending = 3'b100;
            run_op(1'b0, 1'b0, 5, 1'b0);
        end

        // Watchdog abort with a late done landing in RESP.
        mul_delay = 16;
        pending   = 3'b100;
        run_op(1'b0, 1'b0, 16, 1'b1);
        checkOutput("timeout_err_set", R'(timeout_err), R'(1));
        mul_delay = 4;
        quiet_cycles("late_done", 3);
        pending = 3'b010;
        run_op(1'b0, 1'b0, 5, 1'b0);
        checkOutput("timeout_err_sticky", R'(timeout_err), R'(1));

        // Reset in the middle of WAIT.
        applyStimulus(3'b001);
        @(negedge clk);
        checkOutput("t5_mul_start", R'(mul_start), R'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        checkOutput("t5_rsp_valid", R'(rsp_valid), R'(0));
        checkOutput("t5_busy", R'(busy), R'(0));
        checkOutput("t5_mul_b", mul_b, '0);
        checkOutput("t5_rsp_c", rsp_c, '0);
        checkOutput("t5_grant", R'(grant_id), R'(0));
        checkOutput("t5_timeout_err", R'(timeout_err), R'(0));
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        last_ref = NREQ - 1;
        quiet_cycles("t5_post", 2);
        pending = 3'b010;
        run_op(1'b0, 1'b0, 5, 1'b0);
        checkOutput("t5_grant1", R'(grant_id), R'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
